ex_muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide engine beside the single-cycle EX ALU in the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU iteratively and produces HI/LO results.
- Raises a stall request so ID/EX holds while it works.
- Successor to the combinational ALU: generalised data width, configurable multiplier radix, sequential handshake, flush support.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/div_radix2_step.sv | 24 ++
 rtl/ex_muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and latency helpers for the EX-stage multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MUL_BITS = 2;
  localparam int DIVZ_LATENCY = 2;

  function automatic int mul_iters(input int data_w, input int mul_bits);
    return data_w / mul_bits;
  endfunction

  function automatic int mul_latency(input int data_w, input int mul_bits);
    return mul_iters(data_w, mul_bits) + 2;
  endfunction

  function automatic int div_latency(input int data_w);
    return data_w + 2;
  endfunction

  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return o[0];
  endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One combinational iteration of radix-2 restoring division on unsigned magnitudes.
module div_radix2_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              quot_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem < divisor always holds, so a non-negative trial difference never sets
  // bit DATA_W and a negative one always does: that bit is the borrow.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = ~diff[DATA_W];
    rem_next = quot_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine beside the EX ALU; stalls ID/EX while working.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MUL_BITS = DEF_MUL_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              flush,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int MUL_ITERS = mul_iters(DATA_W, MUL_BITS);
  localparam int CNT_W     = $clog2(DATA_W);
  localparam int PP_W      = DATA_W + MUL_BITS;

  function automatic logic [DATA_W-1:0] cond_neg_w(input logic [DATA_W-1:0] x, input logic en);
    return en ? (~x + DATA_W'(1)) : x;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg_2w(input logic [2*DATA_W-1:0] x, input logic en);
    return en ? (~x + (2*DATA_W)'(1)) : x;
  endfunction

  md_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;

  md_op_t              op_q;
  logic                neg_a, neg_b, div_zero;
  logic [DATA_W-1:0]   op1_q, a_mag, b_mag, rem, quo;
  logic [2*DATA_W-1:0] acc;

  logic                sgn_1, sgn_2;
  logic [DATA_W-1:0]   mag_1, mag_2;
  logic [MUL_BITS-1:0] digit;
  logic [PP_W-1:0]     pp, psum;
  logic [DATA_W-1:0]   rem_nxt;
  logic                q_bit;
  logic signed [2*DATA_W-1:0] prod_fix;

  // Acceptance: the core works on magnitudes, signs are kept aside for FIX.
  assign sgn_1 = op_is_signed(op) & operand_1[DATA_W-1];
  assign sgn_2 = op_is_signed(op) & operand_2[DATA_W-1];
  assign mag_1 = cond_neg_w(operand_1, sgn_1);
  assign mag_2 = cond_neg_w(operand_2, sgn_2);

  // Multiply iteration: add multiplicand times the low multiplier digit, shift right.
  assign digit = acc[MUL_BITS-1:0];
  assign pp    = PP_W'(a_mag) * PP_W'(digit);
  assign psum  = PP_W'(acc[2*DATA_W-1:DATA_W]) + pp;

  div_radix2_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem          (rem),
    .dividend_bit (quo[DATA_W-1]),
    .divisor      (b_mag),
    .rem_next     (rem_nxt),
    .quot_bit     (q_bit)
  );

  assign prod_fix = cond_neg_2w(acc, neg_a ^ neg_b);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (!op_is_div(op))         state_nxt = ST_MUL;
            else if (operand_2 == '0)   state_nxt = ST_FIX;
            else                        state_nxt = ST_DIV;
          end
        end
        ST_MUL:  if (cnt == '0) state_nxt = ST_FIX;
        ST_DIV:  if (cnt == '0) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  assign stall_req = start & ~done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      cnt <= op_is_div(op) ? CNT_W'(DATA_W - 1) : CNT_W'(MUL_ITERS - 1);
    end else if (state == ST_MUL || state == ST_DIV) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Operands reload every IDLE cycle, so whatever is present at the accepting edge sticks.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        op_q     <= md_op_t'(op);
        op1_q    <= operand_1;
        neg_a    <= sgn_1;
        neg_b    <= sgn_2;
        a_mag    <= mag_1;
        b_mag    <= mag_2;
        div_zero <= (operand_2 == '0);
        acc      <= {DATA_W'(0), mag_2};
        rem      <= '0;
        quo      <= mag_1;
      end
      ST_MUL: acc <= {psum, acc[DATA_W-1:MUL_BITS]};
      ST_DIV: begin
        rem <= rem_nxt;
        quo <= {quo[DATA_W-2:0], q_bit};
      end
      default: ;
    endcase
  end

  // FIX: sign correction; hi/lo change only here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX && !flush) begin
      if (!op_is_div(op_q)) begin
        {hi, lo} <= prod_fix;
      end else if (div_zero) begin
        hi <= op1_q;
        lo <= '1;
      end else begin
        lo <= cond_neg_w(quo, neg_a ^ neg_b);
        hi <= cond_neg_w(rem, neg_a);
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: default build plus a MUL_BITS=1 build.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, start1 = 1'b0, flush = 1'b0, flush1 = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] operand_1 = '0, operand_2 = '0;
  logic stall_req, busy, done, stall_req1, busy1, done1;
  logic [W-1:0] hi, lo, hi1, lo1;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  ex_muldiv_unit #(.DATA_W(W), .MUL_BITS(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .operand_1(operand_1), .operand_2(operand_2),
    .stall_req(stall_req), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  ex_muldiv_unit #(.DATA_W(W), .MUL_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .flush(flush1),
    .operand_1(operand_1), .operand_2(operand_2),
    .stall_req(stall_req1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder follows the dividend, exactly the MIPS rules.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int k, input int mul_lat);
    exp_t e;
    logic [63:0] p;
    longint x, y;
    int lat;
    lat = 34;
    if (o == 2'b00) begin
      p = {32'b0, a} * {32'b0, b};
      lat = mul_lat;
    end else if (o == 2'b01) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      p = x * y;
      lat = mul_lat;
    end else if (b == 0) begin
      p = {a, 32'hFFFF_FFFF};
      lat = 2;
    end else if (o == 2'b10) begin
      p = {a % b, a / b};
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      p = {32'(x % y), 32'(x / y)};
    end
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.cyc = k + lat;
    return e;
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done) begin
      if (q0.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done0: got done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = q0.pop_front();
        check("hi0", hi, e.hi);
        check("lo0", lo, e.lo);
        check_int("done_cycle0", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done1: got done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = q1.pop_front();
        check("hi1", hi1, e.hi);
        check("lo1", lo1, e.lo);
        check_int("done_cycle1", cyc, e.cyc);
      end
    end
  end

  // All stimulus tasks start and end at posedge+#1.
  task automatic wait_idle(input int unit);
    int n = 0;
    while ((unit == 0 ? busy : busy1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      n_vec++; n_bad++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic issue(input int unit, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit hold);
    wait_idle(unit);
    op = o; operand_1 = a; operand_2 = b;
    if (unit == 0) begin
      start = 1'b1;
      q0.push_back(model(o, a, b, cyc, 18));
    end else begin
      start1 = 1'b1;
      q1.push_back(model(o, a, b, cyc, 34));
    end
    if (!hold) begin
      @(posedge clk); #1;
      start = 1'b0; start1 = 1'b0;
      op = 2'($urandom); operand_1 = $urandom; operand_2 = $urandom;
    end
  endtask

  task automatic wait_done(output int dcyc);
    int n = 0;
    dcyc = -1;
    while (n < 200) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
      n++;
    end
    if (dcyc < 0) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, required a pulse", n);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, k, d1, d2;
    logic [W-1:0] hi_keep, lo_keep;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_stall", {31'b0, stall_req}, 32'd0);
    check("reset_busy1", {31'b0, busy1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // MULTU with start held: stall_req high through the done cycle exclusive.
    issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!stall_req) break;
      n++;
    end
    check_int("stall_cycles", n, 18);
    @(posedge clk); #1;
    start = 1'b0;

    issue(0, 2'b01, -32'sd3, 32'd7, 1'b0);
    issue(1, 2'b01, -32'sd3, 32'd7, 1'b0);
    issue(0, 2'b11, -32'sd7, 32'd2, 1'b0);
    issue(0, 2'b10, 32'd100, 32'd7, 1'b0);
    issue(0, 2'b10, 32'd5, 32'd0, 1'b0);
    issue(0, 2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0);
    issue(0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush on the fifth cycle after acceptance.
    wait_idle(0);
    hi_keep = hi; lo_keep = lo;
    op = 2'b00; operand_1 = $urandom; operand_2 = $urandom; start = 1'b1;
    k = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < k + 5) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_hi", hi, hi_keep);
    check("flush_lo", lo, lo_keep);
    @(posedge clk); #1;
    // flush beats start in IDLE
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("flush_vs_start_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // Reset in the middle of a divide.
    op = 2'b11; operand_1 = 32'd1000; operand_2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_hi", hi, '0);
    check("midrst_lo", lo, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    // Back-to-back with start held: IDLE for one cycle, then a full divide.
    issue(0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_done(d1);
    op = 2'b10; operand_1 = 32'hDEAD_BEEF; operand_2 = 32'd12345;
    q0.push_back(model(op, operand_1, operand_2, cyc, 18));
    wait_done(d2);
    start = 1'b0;
    check_int("b2b_done_gap", d2 - d1, 35);

    for (int i = 0; i < 40; i++) begin
      issue((i % 8 == 7) ? 1 : 0, 2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
    end

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_int("queue_drained", q0.size() + q1.size(), 0);
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
